// File: rtl/td4_prog_mem.sv
// 16x8 loadable program memory for the TD4 core, written nibble-wise over a valid/ready port.
// Optional TD4_PMEM_CHECKSUM_EN adds a cksum port (mod-256 sum of words written since load_start).
module td4_prog_mem #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic          run_req,
  input  logic          ld_valid,
  input  logic [3:0]    ld_nibble,
  output logic          ld_ready,
  input  logic [AW-1:0] cpu_addr,
  output logic [DW-1:0] cpu_data,
  output logic          cpu_run,
  output logic          load_done,
`ifdef TD4_PMEM_CHECKSUM_EN
  output logic [7:0]    cksum,
`endif
  output logic [AW-1:0] wptr
);

  localparam int DEPTH = 2**AW;

  typedef enum logic [1:0] {IDLE, LOAD_HI, LOAD_LO, RUN} state_t;

  state_t        state;
  logic [3:0]    hold;
  logic [DW-1:0] mem [DEPTH];

  assign cpu_data = mem[cpu_addr];

  // Control pulses take priority over nibble accepts; load_start beats run_req.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wptr      <= '0;
      hold      <= '0;
      ld_ready  <= 1'b0;
      cpu_run   <= 1'b0;
      load_done <= 1'b0;
`ifdef TD4_PMEM_CHECKSUM_EN
      cksum     <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      load_done <= 1'b0;
      if (load_start) begin
        state    <= LOAD_HI;
        wptr     <= '0;
        ld_ready <= 1'b1;
        cpu_run  <= 1'b0;
`ifdef TD4_PMEM_CHECKSUM_EN
        cksum    <= '0;
`endif
      end else if (run_req && state != RUN) begin
        state    <= RUN;
        ld_ready <= 1'b0;
        cpu_run  <= 1'b1;
      end else begin
        case (state)
          LOAD_HI: begin
            if (ld_valid) begin
              hold  <= ld_nibble;
              state <= LOAD_LO;
            end
          end
          LOAD_LO: begin
            if (ld_valid) begin
              mem[wptr] <= {hold, ld_nibble};
`ifdef TD4_PMEM_CHECKSUM_EN
              cksum     <= cksum + {hold, ld_nibble};
`endif
              if (wptr == AW'(DEPTH - 1)) begin
                wptr      <= '0;
                state     <= RUN;
                ld_ready  <= 1'b0;
                cpu_run   <= 1'b1;
                load_done <= 1'b1;
              end else begin
                wptr  <= wptr + 1'b1;
                state <= LOAD_HI;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_td4_prog_mem.sv
// Randomized self-checking bench for td4_prog_mem against a word-level reference model.
// Build with TD4_PMEM_CHECKSUM_EN defined to also exercise the cksum port.
module tb_td4_prog_mem;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_start = 1'b0;
  logic       run_req = 1'b0;
  logic       ld_valid = 1'b0;
  logic [3:0] ld_nibble = 4'h0;
  logic       ld_ready;
  logic [3:0] cpu_addr = 4'h0;
  logic [7:0] cpu_data;
  logic       cpu_run;
  logic       load_done;
  logic [3:0] wptr;
`ifdef TD4_PMEM_CHECKSUM_EN
  logic [7:0] cksum;
`endif

  td4_prog_mem dut (
    .clk(clk), .rst(rst), .load_start(load_start), .run_req(run_req),
    .ld_valid(ld_valid), .ld_nibble(ld_nibble), .ld_ready(ld_ready),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_run(cpu_run),
    .load_done(load_done),
`ifdef TD4_PMEM_CHECKSUM_EN
    .cksum(cksum),
`endif
    .wptr(wptr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: program image plus a description of where the loader is.
  logic [7:0] m_mem [16];
  bit         m_loading, m_running, m_have_hi;
  logic [3:0] m_hi;
  int         m_wp;
  logic [7:0] m_ck;
  bit         exp_done;
  int         done_seen, done_exp;

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    foreach (m_mem[i]) m_mem[i] = 8'h00;
    m_loading = 0; m_running = 0; m_have_hi = 0; m_wp = 0; m_ck = 0; exp_done = 0;
  endtask

  task automatic drive(input bit ls, input bit rr, input bit v, input logic [3:0] nib);
    load_start = ls; run_req = rr; ld_valid = v; ld_nibble = nib;
    exp_done = 0;
    if (ls) begin
      m_loading = 1; m_running = 0; m_have_hi = 0; m_wp = 0; m_ck = 0;
    end else if (rr && !m_running) begin
      m_loading = 0; m_running = 1; m_have_hi = 0;
    end else if (m_loading && v) begin
      if (!m_have_hi) begin
        m_hi = nib; m_have_hi = 1;
      end else begin
        m_mem[m_wp] = {m_hi, nib};
        m_ck = m_ck + {m_hi, nib};
        m_have_hi = 0;
        if (m_wp == 15) begin
          m_wp = 0; m_loading = 0; m_running = 1; exp_done = 1;
        end else m_wp++;
      end
    end
    @(posedge clk); #1;
    load_start = 0; run_req = 0; ld_valid = 0;
    if (load_done === 1'b1) done_seen++;
    if (exp_done) done_exp++;
  endtask

  task automatic send_word(input logic [7:0] w, input int max_gap);
    for (int g = $urandom_range(max_gap, 0); g > 0; g--) drive(0, 0, 0, 4'($urandom));
    drive(0, 0, 1, w[7:4]);
    for (int g = $urandom_range(max_gap, 0); g > 0; g--) drive(0, 0, 0, 4'($urandom));
    drive(0, 0, 1, w[3:0]);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (cpu_run !== 1'b0 || ld_ready !== 1'b0 || load_done !== 1'b0 || wptr !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got run=%b rdy=%b done=%b wptr=%h, want 0 0 0 0",
               cpu_run, ld_ready, load_done, wptr);
    end
    for (int a = 0; a < 16; a++) begin
      cpu_addr = 4'(a); #1;
      n_tests++;
      if (cpu_data !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_mem[%0d]: got %h want 00", a, cpu_data);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_load();
    done_seen = 0; done_exp = 0;
    drive(1, 0, 0, 4'h0);
    n_tests++;
    if (ld_ready !== 1'b1 || cpu_run !== 1'b0) begin
      n_fail++;
      $display("FAIL load_enter: got rdy=%b run=%b want 1 0", ld_ready, cpu_run);
    end
    for (int i = 0; i < 16; i++) send_word({4'hB, 4'(i)}, 2);
    n_tests++;
    if (load_done !== 1'b1 || cpu_run !== 1'b1 || ld_ready !== 1'b0 || wptr !== 4'h0) begin
      n_fail++;
      $display("FAIL full_load_end: got done=%b run=%b rdy=%b wptr=%h want 1 1 0 0",
               load_done, cpu_run, ld_ready, wptr);
    end
    drive(0, 0, 0, 4'h0);
    n_tests++;
    if (load_done !== 1'b0 || done_seen != 1 || done_exp != 1) begin
      n_fail++;
      $display("FAIL load_done_pulse: got done=%b pulses=%0d want 0 1", load_done, done_seen);
    end
    cpu_addr = 4'd5; #1;
    n_tests++;
    if (cpu_data !== 8'hB5) begin
      n_fail++;
      $display("FAIL word5: got %h want b5", cpu_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random_load();
    for (int r = 0; r < 2; r++) begin
      drive(1, 0, 0, 4'h0);
      for (int i = 0; i < 16; i++) send_word(8'($urandom), r);
      n_tests++;
      if (cpu_run !== 1'b1 || load_done !== 1'b1 || wptr !== 4'h0) begin
        n_fail++;
        $display("FAIL rand_load_end[%0d]: got run=%b done=%b wptr=%h", r, cpu_run, load_done, wptr);
      end
`ifdef TD4_PMEM_CHECKSUM_EN
      n_tests++;
      if (cksum !== m_ck) begin
        n_fail++;
        $display("FAIL rand_cksum[%0d]: got %h want %h", r, cksum, m_ck);
      end
`endif
      for (int a = 0; a < 16; a++) begin
        cpu_addr = 4'(a); #1;
        n_tests++;
        if (cpu_data !== m_mem[a]) begin
          n_fail++;
          $display("FAIL rand_mem[%0d]: got %h want %h", a, cpu_data, m_mem[a]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_partial_abort();
    done_seen = 0;
    drive(1, 0, 0, 4'h0);
    send_word(8'h31, 1); send_word(8'h52, 1); send_word(8'h73, 1);
    n_tests++;
    if (wptr !== 4'd3) begin
      n_fail++;
      $display("FAIL partial_wptr: got %h want 3", wptr);
    end
    drive(0, 0, 1, 4'hA);
    drive(0, 1, 0, 4'h0);
    n_tests++;
    if (cpu_run !== 1'b1 || ld_ready !== 1'b0 || load_done !== 1'b0 || done_seen != 0) begin
      n_fail++;
      $display("FAIL abort_ctrl: got run=%b rdy=%b done=%b pulses=%0d want 1 0 0 0",
               cpu_run, ld_ready, load_done, done_seen);
    end
    for (int a = 0; a < 16; a++) begin
      cpu_addr = 4'(a); #1;
      n_tests++;
      if (cpu_data !== m_mem[a]) begin
        n_fail++;
        $display("FAIL abort_mem[%0d]: got %h want %h", a, cpu_data, m_mem[a]);
      end
    end
    @(posedge clk); #1;
    drive(0, 1, 0, 4'h0);
    n_tests++;
    if (cpu_run !== 1'b1 || ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL run_req_in_run: got run=%b rdy=%b want 1 0", cpu_run, ld_ready);
    end
  endtask

  task automatic test_restart_midword();
    drive(1, 0, 0, 4'h0);
    drive(0, 0, 1, 4'h7);
    drive(1, 0, 0, 4'h0);
    drive(0, 0, 1, 4'hE);
    drive(0, 0, 1, 4'h1);
    cpu_addr = 4'd0; #1;
    n_tests++;
    if (cpu_data !== 8'hE1 || m_mem[0] !== 8'hE1 || wptr !== 4'd1) begin
      n_fail++;
      $display("FAIL restart_midword: got word0=%h wptr=%h want e1 1", cpu_data, wptr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_collisions();
    drive(0, 1, 0, 4'h0);
    drive(1, 1, 0, 4'h0);
    n_tests++;
    if (ld_ready !== 1'b1 || cpu_run !== 1'b0 || wptr !== 4'h0) begin
      n_fail++;
      $display("FAIL start_beats_run: got rdy=%b run=%b wptr=%h want 1 0 0", ld_ready, cpu_run, wptr);
    end
    drive(0, 0, 1, 4'h3);
    drive(1, 0, 1, 4'h9);
    drive(0, 0, 1, 4'h4);
    drive(0, 1, 1, 4'h6);
    cpu_addr = 4'd0; #1;
    n_tests++;
    if (cpu_data !== m_mem[0] || cpu_run !== 1'b1 || wptr !== 4'h0) begin
      n_fail++;
      $display("FAIL pulse_beats_accept: got word0=%h run=%b wptr=%h want %h 1 0",
               cpu_data, cpu_run, wptr, m_mem[0]);
    end
    @(posedge clk); #1;
    drive(1, 0, 0, 4'h0);
    send_word(8'h5A, 0);
    drive(0, 0, 1, 4'hC);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    foreach (m_mem[i]) m_mem[i] = 8'h00;
    m_loading = 0; m_running = 0; m_have_hi = 0; m_wp = 0; m_ck = 0;
    n_tests++;
    if (cpu_run !== 1'b0 || ld_ready !== 1'b0 || wptr !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_midload: got run=%b rdy=%b wptr=%h want 0 0 0", cpu_run, ld_ready, wptr);
    end
    for (int a = 0; a < 16; a++) begin
      cpu_addr = 4'(a); #1;
      n_tests++;
      if (cpu_data !== 8'h00) begin
        n_fail++;
        $display("FAIL rst_midload_mem[%0d]: got %h want 00", a, cpu_data);
      end
    end
    @(posedge clk); #1;
  endtask

`ifdef TD4_PMEM_CHECKSUM_EN
  task automatic test_checksum();
    drive(1, 0, 0, 4'h0);
    n_tests++;
    if (cksum !== 8'h00) begin
      n_fail++;
      $display("FAIL cksum_clear: got %h want 00", cksum);
    end
    send_word(8'hFF, 1);
    send_word(8'h02, 1);
    drive(0, 1, 0, 4'h0);
    n_tests++;
    if (cksum !== 8'h01) begin
      n_fail++;
      $display("FAIL cksum_sum: got %h want 01", cksum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_load();
    test_random_load();
    test_partial_abort();
    test_restart_midword();
    test_collisions();
`ifdef TD4_PMEM_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
